// File: rtl/evu_event_scheduler_if.sv
// Valid/ready record port between the event scheduler and the SPU consumer.
// A record carries the granted lane, its coalesced count and the {priv, asid} tag.
interface evu_event_scheduler_if #(
    parameter int NUM_LANES  = 4,
    parameter int CNT_WIDTH  = 8,
    parameter int ASID_WIDTH = 16
);
    localparam int IDW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic                  evt_valid;
    logic                  evt_ready;
    logic [IDW-1:0]        evt_id;
    logic [CNT_WIDTH-1:0]  evt_count;
    logic [ASID_WIDTH+1:0] evt_info;

    modport master (
        output evt_valid, evt_id, evt_count, evt_info,
        input  evt_ready
    );

    modport slave (
        input  evt_valid, evt_id, evt_count, evt_info,
        output evt_ready
    );
endinterface

// File: rtl/evu_event_scheduler.sv
// Per-lane saturating event accumulators with a round-robin grant into a
// single registered output slot, so stalled consumers never drop events.
//
// state    | meaning
// ---------|-------------------------------------------------------------
// ST_EMPTY | no record presented, evt_valid low
// ST_FULL  | record registered and presented, held until handshake/flush
module evu_event_scheduler #(
    parameter int NUM_LANES  = 4,
    parameter int CNT_WIDTH  = 8,
    parameter int ASID_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_LANES-1:0]  event_i,
    input  logic [NUM_LANES-1:0]  lane_en_i,
    input  logic                  flush_i,
    input  logic [1:0]            priv_lvl_i,
    input  logic [ASID_WIDTH-1:0] asid_i,
    output logic [NUM_LANES-1:0]  overflow_o,
    input  logic                  overflow_clr_i,
    evu_event_scheduler_if.master evt
);
    localparam int IDW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {ST_EMPTY, ST_FULL} state_e;

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q [NUM_LANES];
    logic [CNT_WIDTH-1:0]    cnt_d [NUM_LANES];
    logic [IDW-1:0]          rr_ptr_q, rr_next;
    logic [IDW-1:0]          id_q;
    logic [CNT_WIDTH-1:0]    count_q;
    logic [ASID_WIDTH+1:0]   info_q;
    logic [NUM_LANES-1:0]    overflow_q, ovf_set, inc;
    logic [IDW-1:0]          cand, grant_lane;
    logic                    found, slot_free, grant;

    assign inc       = event_i & lane_en_i;
    assign slot_free = (state_q == ST_EMPTY) || evt.evt_ready;
    assign grant     = found && slot_free && !flush_i;

    // First non-empty lane at or after rr_ptr, wrapping.
    always_comb begin
        found      = 1'b0;
        grant_lane = '0;
        cand       = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            cand = IDW'((int'(rr_ptr_q) + i) % NUM_LANES);
            if (!found && (cnt_q[cand] != '0)) begin
                found      = 1'b1;
                grant_lane = cand;
            end
        end
    end

    assign rr_next = (grant_lane == IDW'(NUM_LANES - 1)) ? '0 : grant_lane + IDW'(1);

    always_comb begin
        state_d = state_q;
        if (flush_i)
            state_d = ST_EMPTY;
        else if (slot_free)
            state_d = found ? ST_FULL : ST_EMPTY;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state_q <= ST_EMPTY;
        else
            state_q <= state_d;
    end

    // A granted lane restarts from the same-cycle event so nothing is lost.
    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            cnt_d[k]   = cnt_q[k];
            ovf_set[k] = 1'b0;
            if (flush_i) begin
                cnt_d[k] = '0;
            end else if (grant && (grant_lane == IDW'(k))) begin
                cnt_d[k] = inc[k] ? CNT_WIDTH'(1) : '0;
            end else if (inc[k]) begin
                if (cnt_q[k] == CNT_MAX)
                    ovf_set[k] = 1'b1;
                else
                    cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_LANES; k++)
                cnt_q[k] <= '0;
            overflow_q <= '0;
        end else begin
            for (int k = 0; k < NUM_LANES; k++)
                cnt_q[k] <= cnt_d[k];
            overflow_q <= (overflow_q & ~{NUM_LANES{overflow_clr_i}}) | ovf_set;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            id_q     <= '0;
            count_q  <= '0;
            info_q   <= '0;
        end else if (grant) begin
            rr_ptr_q <= rr_next;
            id_q     <= grant_lane;
            count_q  <= cnt_q[grant_lane];
            info_q   <= {priv_lvl_i, asid_i};
        end
    end

    assign evt.evt_valid = (state_q == ST_FULL);
    assign evt.evt_id    = id_q;
    assign evt.evt_count = count_q;
    assign evt.evt_info  = info_q;
    assign overflow_o    = overflow_q;
endmodule

// File: tb/tb_evu_event_scheduler.sv
// Directed bench for evu_event_scheduler: expected records are queued at
// stimulus time and a negedge monitor pops them on each handshake.
module tb_evu_event_scheduler;
    typedef struct packed {
        logic [1:0]  id;
        logic [7:0]  cnt;
        logic [17:0] info;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  event_v;
    logic [3:0]  lane_en;
    logic        flush;
    logic [1:0]  priv;
    logic [15:0] asid;
    logic [3:0]  overflow;
    logic        ovf_clr;

    int   n_checks = 0;
    int   n_fail   = 0;
    rec_t exp_q[$];
    rec_t mon_exp;

    evu_event_scheduler_if #(.NUM_LANES(4), .CNT_WIDTH(8), .ASID_WIDTH(16)) evt_if ();

    evu_event_scheduler #(.NUM_LANES(4), .CNT_WIDTH(8), .ASID_WIDTH(16)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .event_i        (event_v),
        .lane_en_i      (lane_en),
        .flush_i        (flush),
        .priv_lvl_i     (priv),
        .asid_i         (asid),
        .overflow_o     (overflow),
        .overflow_clr_i (ovf_clr),
        .evt            (evt_if.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] id, input logic [7:0] cnt);
        exp_q.push_back('{id: id, cnt: cnt, info: {priv, asid}});
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || evt_if.evt_valid) && n < budget) begin
            tick();
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    always @(negedge clk) begin
        if (rst_n && evt_if.evt_valid && evt_if.evt_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_record: got id %0d count %0d expected no record",
                         evt_if.evt_id, evt_if.evt_count);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rec_id",    32'(evt_if.evt_id),    32'(mon_exp.id));
                check("rec_count", 32'(evt_if.evt_count), 32'(mon_exp.cnt));
                check("rec_info",  32'(evt_if.evt_info),  32'(mon_exp.info));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        event_v = '0;
        lane_en = 4'b1111;
        flush   = 1'b0;
        priv    = 2'b01;
        asid    = 16'h00A5;
        ovf_clr = 1'b0;
        evt_if.evt_ready = 1'b0;
        #3;
        check("rst_valid",    32'(evt_if.evt_valid), 32'd0);
        check("rst_id",       32'(evt_if.evt_id),    32'd0);
        check("rst_count",    32'(evt_if.evt_count), 32'd0);
        check("rst_info",     32'(evt_if.evt_info),  32'd0);
        check("rst_overflow", 32'(overflow),         32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single event on lane 2; info sampled in the grant cycle.
        evt_if.evt_ready = 1'b1;
        event_v = 4'b0100;
        exp_q.push_back('{id: 2'd2, cnt: 8'd1, info: {2'b10, 16'h1111}});
        tick();
        event_v = '0;
        priv    = 2'b10;
        asid    = 16'h1111;
        check("single_t1_valid", 32'(evt_if.evt_valid), 32'd0);
        tick();
        check("single_t2_valid", 32'(evt_if.evt_valid), 32'd1);
        tick();
        check("single_t3_valid", 32'(evt_if.evt_valid), 32'd0);
        wait_drain(10);

        // Round-robin from a fresh pointer.
        do_reset();
        priv = 2'b11;
        asid = 16'hBEEF;
        event_v = 4'b1111;
        push(2'd0, 8'd1);
        push(2'd1, 8'd1);
        push(2'd2, 8'd1);
        push(2'd3, 8'd1);
        tick();
        event_v = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_b2b_valid", 32'(evt_if.evt_valid), 32'd1);
        end
        tick();
        check("rr_idle_valid", 32'(evt_if.evt_valid), 32'd0);
        event_v = 4'b1001;
        push(2'd0, 8'd1);
        push(2'd3, 8'd1);
        tick();
        event_v = '0;
        wait_drain(10);

        // Stall coalescing on lane 1.
        evt_if.evt_ready = 1'b0;
        asid = 16'h0042;
        event_v = 4'b0010;
        push(2'd1, 8'd1);
        push(2'd1, 8'd4);
        repeat (5) tick();
        event_v = '0;
        for (int i = 0; i < 4; i++) begin
            check("stall_valid", 32'(evt_if.evt_valid), 32'd1);
            check("stall_id",    32'(evt_if.evt_id),    32'd1);
            check("stall_count", 32'(evt_if.evt_count), 32'd1);
            tick();
        end
        evt_if.evt_ready = 1'b1;
        wait_drain(10);

        // Saturation and overflow flag behaviour on lane 0.
        evt_if.evt_ready = 1'b0;
        event_v = 4'b0001;
        push(2'd0, 8'd1);
        push(2'd0, 8'd255);
        repeat (300) tick();
        check("sat_overflow", 32'(overflow), 32'h1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        event_v = '0;
        check("clr_vs_ovf", 32'(overflow), 32'h1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'h0);
        evt_if.evt_ready = 1'b1;
        wait_drain(10);

        // Grant coincident with a new event on the same lane.
        evt_if.evt_ready = 1'b0;
        event_v = 4'b1000;
        push(2'd3, 8'd1);
        push(2'd3, 8'd2);
        push(2'd3, 8'd1);
        tick();
        tick();
        tick();
        evt_if.evt_ready = 1'b1;
        tick();
        event_v = '0;
        wait_drain(10);

        // Disabled lane ignores its events.
        lane_en = 4'b1101;
        event_v = 4'b0010;
        tick();
        tick();
        event_v = '0;
        lane_en = 4'b1111;
        repeat (4) begin
            tick();
            check("disabled_valid", 32'(evt_if.evt_valid), 32'd0);
        end

        // Flush retracts the record and discards pending and same-cycle events.
        evt_if.evt_ready = 1'b0;
        event_v = 4'b0011;
        tick();
        event_v = '0;
        tick();
        check("pre_flush_valid", 32'(evt_if.evt_valid), 32'd1);
        flush   = 1'b1;
        event_v = 4'b0100;
        tick();
        flush   = 1'b0;
        event_v = '0;
        check("flush_valid", 32'(evt_if.evt_valid), 32'd0);
        evt_if.evt_ready = 1'b1;
        repeat (5) begin
            tick();
            check("post_flush_valid", 32'(evt_if.evt_valid), 32'd0);
        end

        // Asynchronous reset while stalled in FULL.
        evt_if.evt_ready = 1'b0;
        event_v = 4'b0100;
        tick();
        event_v = 4'b0100;
        tick();
        event_v = '0;
        check("pre_rst_valid", 32'(evt_if.evt_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(evt_if.evt_valid), 32'd0);
        check("async_rst_id",    32'(evt_if.evt_id),    32'd0);
        check("async_rst_count", 32'(evt_if.evt_count), 32'd0);
        check("async_rst_info",  32'(evt_if.evt_info),  32'd0);
        check("async_rst_ovf",   32'(overflow),         32'd0);
        tick();
        rst_n = 1'b1;
        evt_if.evt_ready = 1'b1;
        repeat (4) begin
            tick();
            check("post_rst_valid", 32'(evt_if.evt_valid), 32'd0);
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
